sbox_sequencer: RTL and testbench

Time-multiplexed S-box substitution engine for the DES round function. Accepts one 48-bit key-mixed vector per transaction over a valid/ready handshake. Steps the eight 6-bit groups through a shared lookup bank of LANES S-boxes. Returns the 32-bit substituted result (before the P permutation) over a second valid/ready handshake. It lets area-constrained round datapaths trade latency for S-box instances.

---
 rtl/sbox_sequencer_pkg.sv | 29 ++
 rtl/S_Box_1.sv | 10 +
 rtl/S_Box_2.sv | 10 +
 rtl/S_Box_3.sv | 10 +
 rtl/S_Box_4.sv | 10 +
 rtl/S_Box_5.sv | 10 +
 rtl/S_Box_6.sv | 10 +
 rtl/S_Box_7.sv | 10 +
 rtl/S_Box_8.sv | 10 +
 rtl/sbox_select.sv | 24 ++
 rtl/sbox_sequencer.sv | 113 +++++++++++
 tb/tb_sbox_sequencer.sv | 286 ++++++++++++++++++++++++++++
 12 files changed

// File: rtl/sbox_sequencer_pkg.sv
// Shared DES S-box constants, FSM state type and the table lookup helper
// used by the S_Box_n tables.
package sbox_sequencer_pkg;

   localparam int NUM_GROUPS = 8;
   localparam int GROUP_W    = 6;
   localparam int NIBBLE_W   = 4;
   localparam int TABLE_W    = 64 * NIBBLE_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   // Tables are stored row-major with entry 0 in the top nibble; the DES row is
   // the outer bits {b5,b0} and the column the inner bits b4:b1.
   function automatic logic [NIBBLE_W-1:0] sbox_lookup(
      input logic [TABLE_W-1:0] tbl,
      input logic [GROUP_W-1:0] grp
   );
      logic [5:0]         entry;
      logic [TABLE_W-1:0] shifted;
      entry   = {grp[5], grp[0], grp[4:1]};
      shifted = tbl << (NIBBLE_W * entry);
      return shifted[TABLE_W-1 -: NIBBLE_W];
   endfunction

endpackage

// File: rtl/S_Box_1.sv
// DES S-box 1 lookup table.
module S_Box_1
   import sbox_sequencer_pkg::*;
(
   input  logic [GROUP_W-1:0]  group_i,
   output logic [NIBBLE_W-1:0] value_o
);
   assign value_o = sbox_lookup(
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D, group_i);
endmodule

// File: rtl/S_Box_2.sv
// DES S-box 2 lookup table.
module S_Box_2
   import sbox_sequencer_pkg::*;
(
   input  logic [GROUP_W-1:0]  group_i,
   output logic [NIBBLE_W-1:0] value_o
);
   assign value_o = sbox_lookup(
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9, group_i);
endmodule

// File: rtl/S_Box_3.sv
// DES S-box 3 lookup table.
module S_Box_3
   import sbox_sequencer_pkg::*;
(
   input  logic [GROUP_W-1:0]  group_i,
   output logic [NIBBLE_W-1:0] value_o
);
   assign value_o = sbox_lookup(
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C, group_i);
endmodule

// File: rtl/S_Box_4.sv
// DES S-box 4 lookup table.
module S_Box_4
   import sbox_sequencer_pkg::*;
(
   input  logic [GROUP_W-1:0]  group_i,
   output logic [NIBBLE_W-1:0] value_o
);
   assign value_o = sbox_lookup(
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E, group_i);
endmodule

// File: rtl/S_Box_5.sv
// DES S-box 5 lookup table.
module S_Box_5
   import sbox_sequencer_pkg::*;
(
   input  logic [GROUP_W-1:0]  group_i,
   output logic [NIBBLE_W-1:0] value_o
);
   assign value_o = sbox_lookup(
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453, group_i);
endmodule

// File: rtl/S_Box_6.sv
// DES S-box 6 lookup table.
module S_Box_6
   import sbox_sequencer_pkg::*;
(
   input  logic [GROUP_W-1:0]  group_i,
   output logic [NIBBLE_W-1:0] value_o
);
   assign value_o = sbox_lookup(
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D, group_i);
endmodule

// File: rtl/S_Box_7.sv
// DES S-box 7 lookup table.
module S_Box_7
   import sbox_sequencer_pkg::*;
(
   input  logic [GROUP_W-1:0]  group_i,
   output logic [NIBBLE_W-1:0] value_o
);
   assign value_o = sbox_lookup(
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C, group_i);
endmodule

// File: rtl/S_Box_8.sv
// DES S-box 8 lookup table.
module S_Box_8
   import sbox_sequencer_pkg::*;
(
   input  logic [GROUP_W-1:0]  group_i,
   output logic [NIBBLE_W-1:0] value_o
);
   assign value_o = sbox_lookup(
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B, group_i);
endmodule

// File: rtl/sbox_select.sv
// One shared lookup lane: evaluates all eight DES S-boxes on a 6-bit group and
// picks the one named by idx_i (0 = S1 ... 7 = S8).
module sbox_select
   import sbox_sequencer_pkg::*;
(
   input  logic [2:0]          idx_i,
   input  logic [GROUP_W-1:0]  group_i,
   output logic [NIBBLE_W-1:0] value_o
);

   logic [NIBBLE_W-1:0] box_val [NUM_GROUPS];

   S_Box_1 u_s1 (.group_i(group_i), .value_o(box_val[0]));
   S_Box_2 u_s2 (.group_i(group_i), .value_o(box_val[1]));
   S_Box_3 u_s3 (.group_i(group_i), .value_o(box_val[2]));
   S_Box_4 u_s4 (.group_i(group_i), .value_o(box_val[3]));
   S_Box_5 u_s5 (.group_i(group_i), .value_o(box_val[4]));
   S_Box_6 u_s6 (.group_i(group_i), .value_o(box_val[5]));
   S_Box_7 u_s7 (.group_i(group_i), .value_o(box_val[6]));
   S_Box_8 u_s8 (.group_i(group_i), .value_o(box_val[7]));

   assign value_o = box_val[idx_i];

endmodule

// File: rtl/sbox_sequencer.sv
// Time-multiplexed DES S-box engine: steps the eight 6-bit groups of a 48-bit
// vector through LANES shared lookup lanes and returns the 32-bit result.
module sbox_sequencer
   import sbox_sequencer_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [47:0] i_vector,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_vector,
   output logic        o_busy
);

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
         $error("sbox_sequencer: LANES must be 1, 2, 4 or 8");
      end
   endgenerate

   // With LANES=8 the step wraps to zero and the first RUN cycle is also the last.
   localparam logic [2:0] STEP   = 3'(LANES % NUM_GROUPS);
   localparam logic [2:0] LAST_G = 3'(NUM_GROUPS - LANES);

   state_e              state_q;
   logic [47:0]         vec_q;
   logic [NIBBLE_W-1:0] res_q [NUM_GROUPS];
   logic [2:0]          grp_q;
   logic [2:0]          grp_d;
   logic                ready_q;
   logic                valid_q;
   logic                busy_q;

   logic [GROUP_W-1:0]  groups   [NUM_GROUPS];
   logic [2:0]          lane_idx [LANES];
   logic [NIBBLE_W-1:0] lane_val [LANES];

   assign grp_d = grp_q + STEP;

   // Group 0 (S1) sits in the top bits of both the input and the result.
   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_pack
      assign groups[g] = vec_q[(NUM_GROUPS-1-g)*GROUP_W +: GROUP_W];
      assign o_vector[(NUM_GROUPS-1-g)*NIBBLE_W +: NIBBLE_W] = res_q[g];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = grp_q + 3'(l);
      sbox_select u_sel (
         .idx_i   (lane_idx[l]),
         .group_i (groups[lane_idx[l]]),
         .value_o (lane_val[l])
      );
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         grp_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         // NOTE: the result nibbles are an array but still reset, because
         // o_vector must read zero after reset.
         for (int i = 0; i < NUM_GROUPS; i++) res_q[i] <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  vec_q   <= i_vector;
                  grp_q   <= '0;
                  state_q <= ST_RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               for (int l = 0; l < LANES; l++) res_q[lane_idx[l]] <= lane_val[l];
               grp_q <= grp_d;
               if (grp_q == LAST_G) begin
                  state_q <= ST_DONE;
                  valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready = ready_q;
   assign o_valid = valid_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_sbox_sequencer.sv
// Scoreboard bench: four sequencers (LANES 1, 2, 4, 8) checked against a
// table-driven DES S-box model, with directed corner cases and random traffic.
module tb_sbox_sequencer;

   localparam int NDUT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        in_valid  [NDUT];
   logic        out_ready [NDUT];
   logic [47:0] in_vec    [NDUT];
   logic        out_valid [NDUT];
   logic        in_ready  [NDUT];
   logic [31:0] out_vec   [NDUT];
   logic        out_busy  [NDUT];

   logic [31:0] exp_q [NDUT][$];
   int          acc_q [NDUT][$];
   bit          vld_prev [NDUT];

   int errors = 0;
   int checks = 0;

   // Standard DES S-boxes, [box][row][column].
   int sbox_t [8][4][16] = '{
      '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
        '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
      '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
        '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
      '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
        '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
      '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
        '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
      '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
        '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
      '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
        '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
      '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
        '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
      '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
        '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
   };

   function automatic logic [31:0] sbox_model(input logic [47:0] v);
      logic [31:0] r;
      int b, row, col;
      r = '0;
      for (int s = 0; s < 8; s++) begin
         b   = int'((v >> (42 - 6 * s)) & 48'h3F);
         row = 2 * ((b >> 5) & 1) + (b & 1);
         col = (b >> 1) & 15;
         r   = (r << 4) | 32'(sbox_t[s][row][col]);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      localparam int L = 1 << k;

      sbox_sequencer #(.LANES(L)) u_dut (
         .i_clk    (clk),
         .i_rst    (rst),
         .i_valid  (in_valid[k]),
         .o_ready  (out_ready[k]),
         .i_vector (in_vec[k]),
         .o_valid  (out_valid[k]),
         .i_ready  (in_ready[k]),
         .o_vector (out_vec[k]),
         .o_busy   (out_busy[k])
      );

      // Monitor: latency on each rising o_valid, value on each result handshake.
      always @(negedge clk) begin
         if (!rst) begin
            if (out_valid[k] && !vld_prev[k]) begin
               if (acc_q[k].size() == 0) fail($sformatf("unexpected_valid[L=%0d]", L));
               else check($sformatf("latency[L=%0d]", L), 32'(cyc - acc_q[k].pop_front()), 32'(8 / L));
            end
            if (out_valid[k] && in_ready[k]) begin
               if (exp_q[k].size() == 0) fail($sformatf("extra_result[L=%0d]", L));
               else check($sformatf("result[L=%0d]", L), out_vec[k], exp_q[k].pop_front());
            end
         end
         vld_prev[k] = out_valid[k];
      end
   end

   task automatic send(input int d, input logic [47:0] v, input logic [31:0] e);
      int n;
      n = 0;
      in_vec[d]   = v;
      in_valid[d] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!out_ready[d] && n < 500);
      if (!out_ready[d]) begin
         fail($sformatf("accept_timeout[dut%0d]", d));
         in_valid[d] = 1'b0;
         return;
      end
      exp_q[d].push_back(e);
      acc_q[d].push_back(cyc + 1);
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      in_vec[d]   = {16'($urandom), $urandom};
   endtask

   task automatic wait_drain(input int d);
      int n;
      n = 0;
      while (exp_q[d].size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q[d].size() != 0) fail($sformatf("drain_timeout[dut%0d]", d));
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_random(input int d, input int n);
      bit          fin;
      logic [47:0] v;
      fin = 1'b0;
      fork
         begin
            for (int t = 0; t < n; t++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk);
                  #1;
               end
               v = {16'($urandom), $urandom};
               send(d, v, sbox_model(v));
            end
            fin = 1'b1;
         end
         begin
            while (!fin) begin
               @(posedge clk);
               #1;
               in_ready[d] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      in_ready[d] = 1'b1;
      wait_drain(d);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] va, vb;
      int          n;

      rst = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         in_valid[d] = 1'b0;
         in_ready[d] = 1'b1;
         in_vec[d]   = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("reset_ready[dut%0d]", d), 32'(out_ready[d]), 32'd1);
         check($sformatf("reset_valid[dut%0d]", d), 32'(out_valid[d]), 32'd0);
         check($sformatf("reset_busy[dut%0d]", d), 32'(out_busy[d]), 32'd0);
         check($sformatf("reset_vector[dut%0d]", d), out_vec[d], 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Zero vector on LANES=1, all-ones on LANES=8.
      send(0, 48'h0, 32'hEFA72C4D);
      wait_drain(0);
      send(3, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
      wait_drain(3);

      // S8 boundary addresses on LANES=2.
      send(1, 48'h0000_0000_0000, 32'hEFA72C4D);
      send(1, 48'h0000_0000_003F, 32'hEFA72C4B);
      send(1, 48'h0000_0000_0001, 32'hEFA72C41);
      wait_drain(1);

      // Backpressure in DONE with a competing input on LANES=1.
      va = 48'h1234_5678_9ABC;
      vb = 48'hFEDC_BA98_7654;
      in_ready[0] = 1'b0;
      send(0, va, sbox_model(va));
      n = 0;
      while (!out_valid[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid[0]) fail("bp_wait_valid");
      @(posedge clk);
      #1;
      in_valid[0] = 1'b1;
      in_vec[0]   = vb;
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid[0]), 32'd1);
         check("bp_vector", out_vec[0], sbox_model(va));
         check("bp_ready", 32'(out_ready[0]), 32'd0);
         check("bp_busy", 32'(out_busy[0]), 32'd1);
      end
      @(posedge clk);
      #1;
      in_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_idle_ready", 32'(out_ready[0]), 32'd1);
      check("bp_idle_valid", 32'(out_valid[0]), 32'd0);
      exp_q[0].push_back(sbox_model(vb));
      acc_q[0].push_back(cyc + 1);
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      wait_drain(0);

      // Reset during the third RUN cycle aborts the transaction.
      send(0, 48'hA5A5_5A5A_C3C3, sbox_model(48'hA5A5_5A5A_C3C3));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_ready", 32'(out_ready[0]), 32'd1);
      check("rst_valid", 32'(out_valid[0]), 32'd0);
      check("rst_busy", 32'(out_busy[0]), 32'd0);
      check("rst_vector", out_vec[0], 32'h0);
      exp_q[0].delete();
      acc_q[0].delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         check("post_rst_no_valid", 32'(out_valid[0]), 32'd0);
      end
      @(posedge clk);
      #1;
      send(0, 48'h0F0F_F0F0_3C3C, sbox_model(48'h0F0F_F0F0_3C3C));
      wait_drain(0);

      // Random traffic with downstream stalls on every LANES value.
      fork
         run_random(0, 250);
         run_random(1, 250);
         run_random(2, 250);
         run_random(3, 250);
      join

      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("leftover_results[dut%0d]", d), 32'(exp_q[d].size()), 32'd0);
         check($sformatf("leftover_accepts[dut%0d]", d), 32'(acc_q[d].size()), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
